// File: rtl/tcdm_mem_responder.sv
// Single-bank TCDM memory responder: grant FSM with GNT_WAIT wait states, byte-enabled
// word array, one-cycle registered response. Optional range check: TCDM_RESP_RANGE_ERR_EN.
module tcdm_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 9,
    parameter int AUX_WIDTH  = 8,
    parameter int MEM_WORDS  = 1024,
    parameter int GNT_WAIT   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_add_i,
    input  logic                    data_wen_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ID_WIDTH-1:0]     data_ID_i,
    input  logic [AUX_WIDTH-1:0]    data_aux_i,
    output logic                    data_gnt_o,
    output logic [DATA_WIDTH-1:0]   data_r_rdata_o,
    output logic                    data_r_valid_o,
    output logic [ID_WIDTH-1:0]     data_r_ID_o,
    output logic                    data_r_opc_o,
    output logic [AUX_WIDTH-1:0]    data_r_aux_o,
    input  logic [ADDR_WIDTH-1:0]   START_ADDR,
    input  logic [ADDR_WIDTH-1:0]   END_ADDR
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_INIT = (GNT_WAIT > 0) ? 4'(GNT_WAIT - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             w_gnt;
    logic             w_hit;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_opc;
    logic [AUX_WIDTH-1:0]  r_aux;

    // ---------------- grant FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (data_req_i && (GNT_WAIT != 0)) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                // A dropped request abandons the wait without a grant.
                if (!data_req_i || (r_cnt == 4'd0)) w_state_nxt = S_IDLE;
                else                                w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt = 1'b0;
        if (rst_n && data_req_i) begin
            if (GNT_WAIT == 0) w_gnt = (r_state == S_IDLE);
            else               w_gnt = (r_state == S_WAIT) && (r_cnt == 4'd0);
        end
    end

    assign data_gnt_o = w_gnt;

    // ---------------- address decode ----------------
    assign w_off = data_add_i - START_ADDR;
    assign w_idx = w_off[IDX_W+1:2];

`ifdef TCDM_RESP_RANGE_ERR_EN
    localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(32'hBAD0_ACCE);
    assign w_hit = (data_add_i >= START_ADDR) && (data_add_i < END_ADDR);
    logic w_unused;
    assign w_unused = ^{w_off[1:0], w_off[ADDR_WIDTH-1:IDX_W+2]};
`else
    assign w_hit = 1'b1;
    logic w_unused;
    assign w_unused = ^{w_off[1:0], w_off[ADDR_WIDTH-1:IDX_W+2], END_ADDR};
`endif

    always_comb begin
        w_rdata = data_wen_i ? r_mem[w_idx] : '0;
`ifdef TCDM_RESP_RANGE_ERR_EN
        if (!w_hit) w_rdata = ERR_WORD;
`endif
    end

    // ---------------- array (not reset) ----------------
    always_ff @(posedge clk) begin
        if (w_gnt && !data_wen_i && w_hit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (data_be_i[b]) r_mem[w_idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
            end
        end
    end

    // ---------------- response register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_id    <= '0;
            r_opc   <= 1'b0;
            r_aux   <= '0;
        end else begin
            r_valid <= w_gnt;
            if (w_gnt) begin
                r_rdata <= w_rdata;
                r_id    <= data_ID_i;
                r_opc   <= !w_hit;
                r_aux   <= data_aux_i;
            end
        end
    end

    assign data_r_valid_o = r_valid;
    assign data_r_rdata_o = r_rdata;
    assign data_r_ID_o    = r_id;
    assign data_r_opc_o   = r_opc;
    assign data_r_aux_o   = r_aux;

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// Directed bench for tcdm_mem_responder: three instances with GNT_WAIT = 0, 3 and 2
// share request fields and reset; each is exercised in turn with its own req.
module tb_tcdm_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] add = 32'h1000;
    logic        wen = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [8:0]  id = '0;
    logic [7:0]  aux = '0;
    logic        req0 = 1'b0, req2 = 1'b0, req3 = 1'b0;
    logic [31:0] start_a = 32'h1000, end_a = 32'h2000;

    logic        gnt0, gnt2, gnt3, vld0, vld2, vld3, opc0, opc2, opc3;
    logic [31:0] rd0, rd2, rd3;
    logic [8:0]  rid0, rid2, rid3;
    logic [7:0]  raux0, raux2, raux3;

    int n_pass = 0, n_fail = 0, ngnt = 0;

    always #5 clk = ~clk;

    tcdm_mem_responder #(.GNT_WAIT(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .data_req_i(req0), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_ID_i(id), .data_aux_i(aux),
        .data_gnt_o(gnt0), .data_r_rdata_o(rd0), .data_r_valid_o(vld0), .data_r_ID_o(rid0),
        .data_r_opc_o(opc0), .data_r_aux_o(raux0), .START_ADDR(start_a), .END_ADDR(end_a));

    tcdm_mem_responder #(.GNT_WAIT(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .data_req_i(req2), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_ID_i(id), .data_aux_i(aux),
        .data_gnt_o(gnt2), .data_r_rdata_o(rd2), .data_r_valid_o(vld2), .data_r_ID_o(rid2),
        .data_r_opc_o(opc2), .data_r_aux_o(raux2), .START_ADDR(start_a), .END_ADDR(end_a));

    tcdm_mem_responder #(.GNT_WAIT(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .data_req_i(req3), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_ID_i(id), .data_aux_i(aux),
        .data_gnt_o(gnt3), .data_r_rdata_o(rd3), .data_r_valid_o(vld3), .data_r_ID_o(rid3),
        .data_r_opc_o(opc3), .data_r_aux_o(raux3), .START_ADDR(start_a), .END_ADDR(end_a));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic req_set(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic [8:0] i, input logic [7:0] x);
        wen = w; add = a; wdata = d; be = b; id = i; aux = x;
    endtask

    initial begin
        // Reset held with requests pending: no grant may leak out.
        req0 = 1'b1; req2 = 1'b1; req3 = 1'b1;
        req_set(1'b0, 32'h1000, 32'h0, 4'hF, 9'h0, 8'h0);
        mid();
        chk("rst_gnt0", 64'(gnt0), 64'd0);
        chk("rst_gnt2", 64'(gnt2), 64'd0);
        chk("rst_gnt3", 64'(gnt3), 64'd0);
        req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
        wen = 1'b1;
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("idle_gnt0", 64'(gnt0), 64'd0);
            chk("idle_vld0", 64'(vld0), 64'd0);
            chk("idle_rd0", 64'(rd0), 64'd0);
            chk("idle_id0", 64'(rid0), 64'd0);
            chk("idle_opc0", 64'(opc0), 64'd0);
            chk("idle_aux0", 64'(raux0), 64'd0);
            chk("idle_vld3", 64'(vld3), 64'd0);
            cyc();
        end

        // GNT_WAIT=0: store then load back-to-back
        req0 = 1'b1;
        req_set(1'b0, 32'h1000, 32'hA5A5_5A5A, 4'hF, 9'h1F3, 8'h07);
        mid(); chk("st_gnt", 64'(gnt0), 64'd1);
        cyc();
        chk("st_vld", 64'(vld0), 64'd1);
        chk("st_id", 64'(rid0), 64'h1F3);
        chk("st_aux", 64'(raux0), 64'h07);
        chk("st_opc", 64'(opc0), 64'd0);
        chk("st_rd", 64'(rd0), 64'd0);
        req_set(1'b1, 32'h1000, 32'h0, 4'hF, 9'h002, 8'h00);
        mid(); chk("ld_gnt", 64'(gnt0), 64'd1);
        cyc();
        chk("ld_vld", 64'(vld0), 64'd1);
        chk("ld_id", 64'(rid0), 64'h002);
        chk("ld_rd", 64'(rd0), 64'hA5A5_5A5A);

        // Partial store over all-ones word
        req_set(1'b0, 32'h1004, 32'hFFFF_FFFF, 4'hF, 9'h003, 8'h00);
        cyc();
        req_set(1'b0, 32'h1006, 32'h1122_3344, 4'h5, 9'h004, 8'h00);
        cyc();
        req_set(1'b1, 32'h1004, 32'h0, 4'hF, 9'h005, 8'h00);
        cyc();
        chk("pbe_vld", 64'(vld0), 64'd1);
        chk("pbe_rd", 64'(rd0), 64'hFF22_FF44);

        // Out-of-range load at END_ADDR
        req_set(1'b1, 32'h2000, 32'h0, 4'hF, 9'h006, 8'h00);
        cyc();
        chk("oor_vld", 64'(vld0), 64'd1);
`ifdef TCDM_RESP_RANGE_ERR_EN
        chk("oor_opc", 64'(opc0), 64'd1);
        chk("oor_rd", 64'(rd0), 64'hBAD0_ACCE);
        // Out-of-range store must not touch the array either
        req_set(1'b0, 32'h2000, 32'hDEAD_BEEF, 4'hF, 9'h007, 8'h00);
        cyc();
        chk("oor_st_opc", 64'(opc0), 64'd1);
        chk("oor_st_rd", 64'(rd0), 64'hBAD0_ACCE);
`else
        // No range check: index wraps to word 0
        chk("wrap_opc", 64'(opc0), 64'd0);
        chk("wrap_rd", 64'(rd0), 64'hA5A5_5A5A);
`endif
        req_set(1'b1, 32'h1000, 32'h0, 4'hF, 9'h008, 8'h00);
        cyc();
        chk("keep_rd", 64'(rd0), 64'hA5A5_5A5A);
        req0 = 1'b0;
        cyc();
        mid();
        chk("drop_vld", 64'(vld0), 64'd0);
        chk("drop_gnt", 64'(gnt0), 64'd0);

        // GNT_WAIT=3: req held 32 cycles -> grant every 4th cycle
        cyc();
        req_set(1'b1, 32'h1000, 32'h0, 4'hF, 9'h010, 8'h00);
        req3 = 1'b1;
        for (int c = 0; c < 32; c++) begin
            mid();
            chk("w3_gnt", 64'(gnt3), 64'((c % 4) == 3));
            chk("w3_vld", 64'(vld3), 64'(((c % 4) == 0) && (c != 0)));
            if (gnt3) ngnt++;
            cyc();
        end
        req3 = 1'b0;
        mid();
        chk("w3_last_vld", 64'(vld3), 64'd1);
        chk("w3_ngnt", 64'(ngnt), 64'd8);

        // GNT_WAIT=3: request withdrawn mid-wait -> no grant, FSM back to IDLE
        cyc();
        req3 = 1'b1;
        mid(); chk("viol_gnt0", 64'(gnt3), 64'd0);
        cyc();
        req3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk("viol_gnt", 64'(gnt3), 64'd0);
            chk("viol_vld", 64'(vld3), 64'd0);
            cyc();
        end
        req3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk("viol_regnt", 64'(gnt3), 64'(c == 3));
            cyc();
        end
        req3 = 1'b0;

        // GNT_WAIT=2: reset pulsed during WAIT
        cyc();
        req2 = 1'b1;
        mid(); chk("r2_gnt_a", 64'(gnt2), 64'd0);
        cyc();
        rst_n = 1'b0;
        mid();
        chk("r2_rst_gnt", 64'(gnt2), 64'd0);
        chk("r2_rst_vld", 64'(vld2), 64'd0);
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("r2_gnt", 64'(gnt2), 64'(c == 2));
            chk("r2_vld", 64'(vld2), 64'd0);
            cyc();
        end
        req2 = 1'b0;
        mid();
        chk("r2_vld_after", 64'(vld2), 64'd1);
        chk("r2_id", 64'(rid2), 64'h010);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
